// File: rtl/bus_delay_hs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bus_delay_hs
//  Description : Valid/ready delay line with a runtime-selectable depth of
//                1..MAX_DELAY register stages. Stages stall individually
//                under backpressure so bubbles collapse toward the output.
//                A synchronous clear flushes all in-flight data.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_delay_hs #(
  parameter int                   MAX_DELAY = 4,
  parameter int                   BUS_WIDTH = 8,
  parameter logic [BUS_WIDTH-1:0] INIT_VAL  = '0,
  parameter int                   CNT_W     = 3,
  parameter int                   DEF_DELAY = MAX_DELAY
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [CNT_W-1:0]     cfg_delay,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     cur_delay,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] c_max_delay = CNT_W'(MAX_DELAY);
  localparam logic [CNT_W-1:0] c_def_delay = CNT_W'(DEF_DELAY);
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

  // Stage storage, indexed 1..MAX_DELAY; stage 0 is the input port itself.
  logic [MAX_DELAY:1]     r_vld;
  logic [BUS_WIDTH-1:0]   r_dat [1:MAX_DELAY];
  logic [CNT_W-1:0]       r_count;
  logic [CNT_W-1:0]       r_cur_delay;

  logic [CNT_W-1:0]       w_sd;
  logic [MAX_DELAY:1]     w_at;
  logic [MAX_DELAY:1]     w_used;
  logic [MAX_DELAY:1]     w_rdy;
  logic [MAX_DELAY:1]     w_src_vld;
  logic [BUS_WIDTH-1:0]   w_src_dat [1:MAX_DELAY];
  logic                   w_tap_vld;
  logic [BUS_WIDTH-1:0]   w_tap_dat;
  logic                   w_accept;
  logic                   w_out_hs;

  // Clamp the requested delay into the legal 1..MAX_DELAY range.
  always_comb begin
    w_sd = cfg_delay;
    if (cfg_delay == '0) begin
      w_sd = c_one;
    end else if (cfg_delay > c_max_delay) begin
      w_sd = c_max_delay;
    end
  end

  // Decode the active delay into a one-hot tap and a mask of in-use stages.
  always_comb begin
    w_at   = '0;
    w_used = '0;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      w_at[k]   = (r_cur_delay == CNT_W'(k));
      w_used[k] = (CNT_W'(k) <= r_cur_delay);
    end
  end

  // Upstream neighbour of each stage; stage 1 is fed straight from the port.
  always_comb begin
    w_src_vld    = '0;
    w_src_dat    = '{default: INIT_VAL};
    w_src_vld[1] = in_valid;
    w_src_dat[1] = in_data;
    for (int k = 2; k <= MAX_DELAY; k++) begin
      w_src_vld[k] = r_vld[k-1];
      w_src_dat[k] = r_dat[k-1];
    end
  end

  // Ready ripples back from the tap; an empty stage is always ready, which
  // is what lets bubbles be squeezed out while the output is stalled.
  always_comb begin
    logic v_down;
    logic v_cur;
    v_down = 1'b1;
    v_cur  = 1'b1;
    w_rdy  = '0;
    for (int k = MAX_DELAY; k >= 1; k--) begin
      if (!w_used[k]) begin
        v_cur = 1'b1;
      end else if (w_at[k]) begin
        v_cur = ~r_vld[k] | out_ready;
      end else begin
        v_cur = ~r_vld[k] | v_down;
      end
      w_rdy[k] = v_cur;
      v_down   = v_cur;
    end
  end

  // Select the output tap at stage cur_delay.
  always_comb begin
    w_tap_vld = 1'b0;
    w_tap_dat = INIT_VAL;
    for (int k = 1; k <= MAX_DELAY; k++) begin
      if (w_at[k]) begin
        w_tap_vld = r_vld[k];
        w_tap_dat = r_dat[k];
      end
    end
  end

  assign in_ready  = w_rdy[1] & ~clear;
  assign out_valid = w_tap_vld & ~clear;
  assign out_data  = w_tap_dat;
  assign w_accept  = in_valid & in_ready;
  assign w_out_hs  = out_valid & out_ready;
  assign cur_delay = r_cur_delay;
  assign count     = r_count;

  // Stage advance: a ready stage takes its neighbour's valid bit, and only
  // overwrites its data when that neighbour actually holds a word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 1; k <= MAX_DELAY; k++) begin
        r_dat[k] <= INIT_VAL;
      end
    end else if (clear) begin
      r_vld <= '0;
      for (int k = 1; k <= MAX_DELAY; k++) begin
        r_dat[k] <= INIT_VAL;
      end
    end else begin
      for (int k = 1; k <= MAX_DELAY; k++) begin
        if (!w_used[k]) begin
          r_vld[k] <= 1'b0;
          r_dat[k] <= INIT_VAL;
        end else if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          if (w_src_vld[k]) begin
            r_dat[k] <= w_src_dat[k];
          end
        end
      end
    end
  end

  // Occupancy tracking and delay reload; the delay only changes while the
  // pipeline is empty so no in-flight word sees its latency altered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_cur_delay <= c_def_delay;
    end else if (clear) begin
      r_count     <= '0;
      r_cur_delay <= w_sd;
    end else begin
      case ({w_accept, w_out_hs})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      if ((r_count == '0) && !w_accept) begin
        r_cur_delay <= w_sd;
      end
    end
  end

endmodule
`default_nettype wire
